xfer_fsm: RTL and testbench
===========================

// Module: xfer_fsm
// PURPOSE
//  Parametrised register-transfer control FSM covering MOV (reg->reg) and MOVI (imm->reg).
//  Sits beside the fetch FSM in the control unit and is started by its one-hot nextFSM code.
//  Drives the shared-bus source select, the source-register read enable and the one-hot
//  destination write enable, then reports completion.
//  Adds over the single-mode version: configurable register count and write-pulse length,
//  range checking with an error flag, a busy output and an optional memory-complete wait.
// PARAMETERS
//  NUM_REGS    4          registers on the bus; width of rdEn/wEn, range 2..16
//  ARG_W       6          width of the para1/para2 operand fields
//  FSM_W       7          width of nextFSM
//  MY_CODE     7'b0010000 nextFSM value that starts this block
//  ID_W        3          width of busSrcID
//  IMM_SRC_ID  3'b010     busSrcID for the immediate path (MOVI)
//  REG_SRC_ID  3'b001     busSrcID for the register-file path (MOV)
//  WR_CYCLES   1          cycles wEn is held high, range 1..15
// PORTS
//  clk       in   1         clock, rising edge
//  rst       in   1         asynchronous reset, active-high
//  nextFSM   in   FSM_W     one-hot FSM select from fetch; start when == MY_CODE
//  isImm     in   1         1 = MOVI (immediate source), 0 = MOV (register source)
//  para1     in   ARG_W     source register index (MOV only)
//  para2     in   ARG_W     destination register index
//  mfc       in   1         memory-function-complete (port exists only with XFER_MFC_EN)
//  busSrcID  out  ID_W      bus driver select; 0 = bus released
//  rdEn      out  NUM_REGS  one-hot source read enable (MOV only)
//  wEn       out  NUM_REGS  one-hot destination write enable; never more than one bit high
//  done      out  1         one-cycle completion pulse
//  err       out  1         operand out of range; sticky until the next start
//  busy      out  1         high whenever the state is not IDLE
// BEHAVIOUR
//  - Reset: state = IDLE, counter = 0, latched operands = 0, err = 0. All outputs are 0.
//  - States: IDLE, SEL, WRITE, HOLD, DONE. Outputs decode from the registered state and the latched operands.
//  - Start: on an edge with nextFSM == MY_CODE, latch isImm/para1/para2, clear err, go to SEL.
//    The start condition overrides everything else, in every state.
//  - Restart mid-operation: current transfer is aborted. wEn drops in the next cycle and the
//    sequence begins again at SEL. No done pulse is issued for the aborted transfer.
//  - SEL, one cycle:
//    busSrcID = IMM_SRC_ID when isImm, else REG_SRC_ID.
//    rdEn = 1<<para1 when !isImm, else 0.
//    If para2 >= NUM_REGS, or (!isImm and para1 >= NUM_REGS): go to DONE and set err. wEn stays 0.
//    Otherwise go to WRITE and load counter = WR_CYCLES-1.
//  - WRITE: bus and rdEn stay driven; wEn = 1<<para2. Counter decrements each cycle.
//    Leave for HOLD when counter == 0.
//  - HOLD, one cycle: wEn = 0; bus and rdEn stay driven (hold time); go to DONE.
//  - DONE, one cycle: done = 1; busSrcID = 0, rdEn = 0, wEn = 0; go to IDLE.
//  - Latency: done is high in cycle WR_CYCLES+3 after the start edge.
//    Error path: done is high in cycle 2 after the start edge.
//  - Equal para1/para2 on MOV is legal: rdEn and wEn share the same bit.
//  - Index arithmetic is unsigned. Only the low ceil(log2(NUM_REGS)) bits select a register,
//    but the full ARG_W value is range-checked.
//  - nextFSM values other than MY_CODE, including all-zero, the error code and multi-hot values,
//    are ignored.
// CONFIGURATION
//  XFER_MFC_EN defined:
//    - The mfc port is present.
//    - WRITE exits only when counter == 0 AND mfc == 1 in the same cycle. wEn is held while waiting.
//    - An mfc pulse that arrives while counter != 0 is not remembered.
//  XFER_MFC_EN undefined:
//    - No mfc port; WRITE lasts exactly WR_CYCLES cycles.
// TESTING
//  1 Reset: assert rst mid-WRITE -> all outputs 0 immediately; after release, busy = 0 and no done.
//  2 MOVI, defaults: isImm=1, para2=2, start ->
//    busSrcID=3'b010 for 3 cycles; wEn=4'b0100 for 1 cycle; done in cycle 4.
//  3 MOV, WR_CYCLES=3: para1=0, para2=3 ->
//    rdEn=4'b0001 and busSrcID=3'b001 for 5 cycles; wEn=4'b1000 for 3 cycles; done in cycle 6.
//  4 Range error: para2=6'd4 with NUM_REGS=4 ->
//    wEn never asserted; done and err in cycle 2; err held until next start, cleared on that start.
//  5 Restart: second start issued while in WRITE ->
//    SEL re-entered, exactly one done pulse, wEn decodes the new para2.
//  6 XFER_MFC_EN: keep mfc=0 for 5 cycles in WRITE ->
//    wEn held for those 5 cycles; mfc=1 -> HOLD next, then done.

Source files
------------

// File: rtl/xfer_fsm.sv
// Register-transfer control FSM for MOV (reg->reg) and MOVI (imm->reg) on the shared bus.
// Optional feature: define XFER_MFC_EN to add the mfc input and stall WRITE until memory completes.

module xfer_fsm_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             rd_act,
  input  logic             wr_act,
  input  logic [IDX_W-1:0] src_idx,
  input  logic [IDX_W-1:0] dst_idx,
  output logic             rd_en,
  output logic             wr_en
);
  localparam int          LANE_I = LANE;
  localparam logic [IDX_W-1:0] ID = LANE_I[IDX_W-1:0];

  assign rd_en = rd_act && (src_idx == ID);
  assign wr_en = wr_act && (dst_idx == ID);
endmodule

module xfer_fsm #(
  parameter int                NUM_REGS   = 4,
  parameter int                ARG_W      = 6,
  parameter int                FSM_W      = 7,
  parameter logic [FSM_W-1:0]  MY_CODE    = 7'b0010000,
  parameter int                ID_W       = 3,
  parameter logic [ID_W-1:0]   IMM_SRC_ID = 3'b010,
  parameter logic [ID_W-1:0]   REG_SRC_ID = 3'b001,
  parameter int                WR_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FSM_W-1:0]    nextFSM,
  input  logic                isImm,
  input  logic [ARG_W-1:0]    para1,
  input  logic [ARG_W-1:0]    para2,
`ifdef XFER_MFC_EN
  input  logic                mfc,
`endif
  output logic [ID_W-1:0]     busSrcID,
  output logic [NUM_REGS-1:0] rdEn,
  output logic [NUM_REGS-1:0] wEn,
  output logic                done,
  output logic                err,
  output logic                busy
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEL   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             imm_q, imm_d;
  logic [ARG_W-1:0] p1_q, p1_d;
  logic [ARG_W-1:0] p2_q, p2_d;
  logic             err_q, err_d;

  logic start, src_ok, dst_ok, range_ok, mfc_ok, drive, rd_act, wr_act;

  assign start = (nextFSM == MY_CODE);

  // Range check uses the full operand width; only the low IDX_W bits pick the lane.
  assign src_ok   = (32'(p1_q) < 32'(NUM_REGS));
  assign dst_ok   = (32'(p2_q) < 32'(NUM_REGS));
  assign range_ok = dst_ok && (imm_q || src_ok);

`ifdef XFER_MFC_EN
  assign mfc_ok = mfc;
`else
  assign mfc_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    imm_d   = imm_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    err_d   = err_q;
    if (start) begin
      imm_d   = isImm;
      p1_d    = para1;
      p2_d    = para2;
      err_d   = 1'b0;
      state_d = S_SEL;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_SEL: begin
          if (!range_ok) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_WRITE;
            cnt_d   = CNT_W'(WR_CYCLES - 1);
          end
        end
        S_WRITE: begin
          // Counter parks at zero while waiting for mfc; an early mfc is not remembered.
          if (cnt_q == '0) begin
            if (mfc_ok) state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_HOLD:  state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      imm_q   <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      imm_q   <= imm_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      err_q   <= err_d;
    end
  end

  assign drive  = (state_q == S_SEL) || (state_q == S_WRITE) || (state_q == S_HOLD);
  assign rd_act = drive && !imm_q && src_ok;
  assign wr_act = (state_q == S_WRITE);

  assign busSrcID = drive ? (imm_q ? IMM_SRC_ID : REG_SRC_ID) : '0;
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
    xfer_fsm_lane #(.IDX_W(IDX_W), .LANE(g)) u_lane (
      .rd_act (rd_act),
      .wr_act (wr_act),
      .src_idx(p1_q[IDX_W-1:0]),
      .dst_idx(p2_q[IDX_W-1:0]),
      .rd_en  (rdEn[g]),
      .wr_en  (wEn[g])
    );
  end
endmodule

// File: tb/tb_xfer_fsm.sv
// Directed bench for xfer_fsm: instance a uses defaults, instance b uses WR_CYCLES=3.
module tb_xfer_fsm;
  localparam logic [6:0] MY = 7'b0010000;

  logic       clk, rst, isImm, mfc;
  logic [6:0] nextFSM;
  logic [5:0] para1, para2;

  logic [2:0] a_bus, b_bus;
  logic [3:0] a_rd, a_wen, b_rd, b_wen;
  logic       a_done, a_err, a_busy, b_done, b_err, b_busy;

  int checks = 0;
  int errors = 0;
  int dones;

  xfer_fsm dut_a (
    .clk(clk), .rst(rst), .nextFSM(nextFSM), .isImm(isImm), .para1(para1), .para2(para2),
`ifdef XFER_MFC_EN
    .mfc(mfc),
`endif
    .busSrcID(a_bus), .rdEn(a_rd), .wEn(a_wen), .done(a_done), .err(a_err), .busy(a_busy)
  );

  xfer_fsm #(.WR_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .nextFSM(nextFSM), .isImm(isImm), .para1(para1), .para2(para2),
`ifdef XFER_MFC_EN
    .mfc(mfc),
`endif
    .busSrcID(b_bus), .rdEn(b_rd), .wEn(b_wen), .done(b_done), .err(b_err), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (first cycle after the start edge).
  task automatic start(input logic imm, input logic [5:0] p1, input logic [5:0] p2);
    nextFSM = MY;
    isImm   = imm;
    para1   = p1;
    para2   = p2;
    tick();
    nextFSM = '0;
  endtask

  initial begin
    rst = 1'b1; nextFSM = '0; isImm = 1'b0; para1 = '0; para2 = '0; mfc = 1'b1;
    #3;
    chk("reset_a", {18'd0, a_busy, a_done, a_err, a_bus, a_rd, a_wen}, 32'd0);
    chk("reset_b", {18'd0, b_busy, b_done, b_err, b_bus, b_rd, b_wen}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Foreign, error and multi-hot codes are ignored
    nextFSM = 7'b0000001; tick(); chk("ign_onehot", {31'd0, a_busy}, 32'd0);
    nextFSM = 7'b0110000; tick(); chk("ign_multi",  {31'd0, a_busy}, 32'd0);
    nextFSM = 7'b0000000; tick(); chk("ign_multi2", {31'd0, a_busy | b_busy}, 32'd0);

    // MOVI on defaults
    start(1'b1, 6'd0, 6'd2);
    chk("movi_c1_bus", a_bus, 3'b010); chk("movi_c1_wen", a_wen, 4'b0000);
    chk("movi_c1_busy", a_busy, 1'b1); chk("movi_c1_rd", a_rd, 4'b0000);
    tick(); chk("movi_c2_wen", a_wen, 4'b0100); chk("movi_c2_bus", a_bus, 3'b010);
    tick(); chk("movi_c3_wen", a_wen, 4'b0000); chk("movi_c3_bus", a_bus, 3'b010);
    chk("movi_c3_done", a_done, 1'b0);
    tick(); chk("movi_c4_done", a_done, 1'b1); chk("movi_c4_bus", a_bus, 3'b000);
    tick(); chk("movi_c5_done", a_done, 1'b0); chk("movi_c5_busy", a_busy, 1'b0);
    repeat (4) tick();

    // MOV with WR_CYCLES=3
    start(1'b0, 6'd0, 6'd3);
    chk("mov_c1_rd", b_rd, 4'b0001); chk("mov_c1_bus", b_bus, 3'b001); chk("mov_c1_wen", b_wen, 4'b0000);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("mov_write_wen", b_wen, 4'b1000); chk("mov_write_rd", b_rd, 4'b0001);
      chk("mov_write_bus", b_bus, 3'b001);
    end
    tick(); chk("mov_c5_wen", b_wen, 4'b0000); chk("mov_c5_rd", b_rd, 4'b0001);
    chk("mov_c5_bus", b_bus, 3'b001); chk("mov_c5_done", b_done, 1'b0);
    tick(); chk("mov_c6_done", b_done, 1'b1); chk("mov_c6_rd", b_rd, 4'b0000);
    chk("mov_c6_bus", b_bus, 3'b000);
    tick(); chk("mov_c7_busy", b_busy, 1'b0);
    repeat (2) tick();

    // MOV with equal source and destination
    start(1'b0, 6'd3, 6'd3);
    chk("eq_c1_rd", a_rd, 4'b1000);
    tick(); chk("eq_c2_rd", a_rd, 4'b1000); chk("eq_c2_wen", a_wen, 4'b1000);
    repeat (6) tick();

    // Range error, sticky err, cleared by the next start
    start(1'b1, 6'd0, 6'd4);
    chk("err_c1_err", a_err, 1'b0); chk("err_c1_wen", a_wen, 4'b0000); chk("err_c1_bus", a_bus, 3'b010);
    tick(); chk("err_c2_done", a_done, 1'b1); chk("err_c2_err", a_err, 1'b1);
    chk("err_c2_wen", a_wen, 4'b0000);
    tick(); chk("err_c3_busy", a_busy, 1'b0); chk("err_c3_err", a_err, 1'b1);
    repeat (3) tick(); chk("err_sticky", a_err, 1'b1);
    start(1'b1, 6'd0, 6'd6);
    chk("err6_clear", a_err, 1'b0); chk("err6_c1_wen", a_wen, 4'b0000);
    tick(); chk("err6_c2_err", a_err, 1'b1); chk("err6_c2_wen", a_wen, 4'b0000);
    repeat (3) tick();
    start(1'b1, 6'd0, 6'd1);
    chk("err_cleared", a_err, 1'b0);
    repeat (8) tick();

    // Restart while in WRITE
    start(1'b0, 6'd1, 6'd0);
    tick(); chk("rs_c2_wen", b_wen, 4'b0001); chk("rs_c2_done", b_done, 1'b0);
    nextFSM = MY; para2 = 6'd2;
    tick(); nextFSM = '0;
    chk("rs_c3_wen", b_wen, 4'b0000); chk("rs_c3_rd", b_rd, 4'b0010); chk("rs_c3_done", b_done, 1'b0);
    chk("rs_c3_bus", b_bus, 3'b001);
    tick(); chk("rs_c4_wen", b_wen, 4'b0100);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b_done) dones++;
    end
    chk("rs_one_done", dones, 1);
    repeat (2) tick();

    // Reset asserted mid-WRITE
    start(1'b0, 6'd0, 6'd1);
    tick(); chk("rst_pre_wen", b_wen, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_b", {18'd0, b_busy, b_done, b_err, b_bus, b_rd, b_wen}, 32'd0);
    chk("rst_mid_a", {18'd0, a_busy, a_done, a_err, a_bus, a_rd, a_wen}, 32'd0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b_done || b_busy) dones++;
    end
    chk("rst_after_idle", dones, 0);

`ifdef XFER_MFC_EN
    // WRITE stalls until mfc while counter is zero
    mfc = 1'b0;
    start(1'b1, 6'd0, 6'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mfc_wait_wen", a_wen, 4'b1000);
    end
    mfc = 1'b1;
    tick(); chk("mfc_hold_wen", a_wen, 4'b0000); chk("mfc_hold_bus", a_bus, 3'b010);
    chk("mfc_hold_done", a_done, 1'b0);
    tick(); chk("mfc_done", a_done, 1'b1);
    repeat (6) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
